// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word per instruction and hands it to the core.
// Optional `BRANCH_DELAY_SLOT_EN: a taken redirect lands one instruction late (MIPS delay slot).
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] Ins_Addr,
    output logic        ins_valid,
    input  logic        ins_ready,
    input  logic        PCSrc,
    input  logic [31:0] PCSrc_immediate,
    input  logic        Jump,
    input  logic [25:0] Jump_immediate,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_VALID
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic        fetch_done;
    logic        consume;
    logic [31:0] seq;
    logic [31:0] btarget;
    logic [31:0] jtarget;
    logic [31:0] next_pc;

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        imem_req   = 1'b0;
        ins_valid  = 1'b0;
        fetch_done = 1'b0;
        consume    = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    fetch_done = 1'b1;
                    state_nxt  = S_VALID;
                end
            end
            S_VALID: begin
                ins_valid = 1'b1;
                if (ins_ready) begin
                    consume   = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Request is decoded from state, so an async reset drops it immediately.
    assign imem_addr = pc;

    assign seq     = Ins_Addr + 32'd4;
    assign btarget = seq + (PCSrc_immediate << 2);
    assign jtarget = {seq[31:28], Jump_immediate, 2'b00};

`ifdef BRANCH_DELAY_SLOT_EN
    logic        pending;
    logic [31:0] pending_target;
    logic        redirect;
    logic [31:0] redirect_target;

    assign redirect        = Jump | PCSrc;
    assign redirect_target = Jump ? jtarget : btarget;
    // The delay-slot instruction always falls through to the stored target.
    assign next_pc         = pending ? pending_target : seq;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pending        <= 1'b0;
            pending_target <= 32'h0000_0000;
        end else if (consume) begin
            if (pending) begin
                pending <= 1'b0;
            end else if (redirect) begin
                pending        <= 1'b1;
                pending_target <= redirect_target;
            end
        end
    end
`else
    assign next_pc = Jump ? jtarget : (PCSrc ? btarget : seq);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc          <= RESET_PC;
            instruction <= 32'h0000_0000;
            Ins_Addr    <= RESET_PC;
            fetch_count <= 32'h0000_0000;
        end else begin
            if (fetch_done) begin
                instruction <= imem_rdata;
                Ins_Addr    <= pc;
            end
            if (consume) begin
                pc          <= next_pc;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a random core/memory driver feeds a PC-flow model,
// and a monitor checks each presented instruction and each fetch address against it.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] Ins_Addr;
    logic        ins_valid;
    logic        ins_ready;
    logic        PCSrc;
    logic [31:0] PCSrc_immediate;
    logic        Jump;
    logic [25:0] Jump_immediate;
    logic [31:0] fetch_count;

    pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instruction    (instruction),
        .Ins_Addr       (Ins_Addr),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .PCSrc          (PCSrc),
        .PCSrc_immediate(PCSrc_immediate),
        .Jump           (Jump),
        .Jump_immediate (Jump_immediate),
        .fetch_count    (fetch_count)
    );

    always #5 CLK = ~CLK;

    // Instruction memory contents are a fixed function of the address; word 0 is 32'h2008_0005.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h2008_0005;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] count;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    int total = 0;
    int bad   = 0;

    int ack_pct   = 100;
    int ready_pct = 100;
    int br_pct    = 0;
    bit drv_en    = 1'b0;
    bit mon_en    = 1'b0;
    bit prev_valid = 1'b0;

    logic [31:0] m_addr;
    logic [31:0] m_count;
`ifdef BRANCH_DELAY_SLOT_EN
    bit          m_pending;
    logic [31:0] m_ptarget;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic model_reset;
        m_addr  = RESET_PC;
        m_count = 32'd0;
`ifdef BRANCH_DELAY_SLOT_EN
        m_pending = 1'b0;
        m_ptarget = 32'd0;
`endif
        sb.delete();
        sb.push_back('{addr: RESET_PC, instr: mem_word(RESET_PC), count: 32'd0});
    endtask

    // One consumed instruction: decide where the program goes next from the MIPS rules.
    task automatic model_consume;
        logic [31:0] seq;
        logic [31:0] tgt;
        logic [31:0] nxt;
        seq = m_addr + 32'd4;
        if (Jump) tgt = {seq[31:28], Jump_immediate, 2'b00};
        else      tgt = seq + PCSrc_immediate * 32'd4;
`ifdef BRANCH_DELAY_SLOT_EN
        if (m_pending) begin
            nxt       = m_ptarget;
            m_pending = 1'b0;
        end else begin
            nxt = seq;
            if (Jump || PCSrc) begin
                m_pending = 1'b1;
                m_ptarget = tgt;
            end
        end
`else
        nxt = (Jump || PCSrc) ? tgt : seq;
`endif
        m_addr  = nxt;
        m_count = m_count + 32'd1;
        sb.push_back('{addr: nxt, instr: mem_word(nxt), count: m_count});
    endtask

    // Memory responder.
    initial begin
        imem_ack = 1'b0;
        forever begin
            @(negedge CLK);
            imem_ack = ($urandom_range(99) < ack_pct);
        end
    end

    // Core-side driver: branch inputs are noise every cycle and only matter when consumed.
    initial begin
        ins_ready       = 1'b0;
        PCSrc           = 1'b0;
        Jump            = 1'b0;
        PCSrc_immediate = 32'd0;
        Jump_immediate  = 26'd0;
        forever begin
            @(negedge CLK);
            PCSrc = ($urandom_range(99) < br_pct);
            Jump  = ($urandom_range(99) < br_pct / 2);
            case ($urandom_range(2))
                0:       PCSrc_immediate = 32'hFFFF_FFFC;
                1:       PCSrc_immediate = 32'($urandom_range(15));
                default: PCSrc_immediate = $urandom;
            endcase
            Jump_immediate = 26'($urandom);
            if (drv_en && !RST && ins_valid && ($urandom_range(99) < ready_pct)) begin
                ins_ready = 1'b1;
                model_consume();
            end else begin
                ins_ready = 1'b0;
            end
        end
    end

    // Monitor: pops one expectation per presented instruction, checks fetch address while requesting.
    initial begin
        forever begin
            @(negedge CLK);
            if (mon_en && !RST) begin
                if (ins_valid && !prev_valid) begin
                    if (sb.size() == 0) fail_now("present_without_expectation");
                    else cur = sb.pop_front();
                end
                if (ins_valid) begin
                    check("Ins_Addr", Ins_Addr, cur.addr);
                    check("instruction", instruction, cur.instr);
                    check("fetch_count", fetch_count, cur.count);
                    check("req_low_while_valid", 32'(imem_req), 32'd0);
                end
                if (imem_req) begin
                    if (sb.size() == 0) fail_now("fetch_without_expectation");
                    else check("imem_addr", imem_addr, sb[0].addr);
                end
                prev_valid = ins_valid;
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    task automatic wait_consumes(input int n, input int budget);
        logic [31:0] target;
        int cyc;
        target = m_count + 32'(n);
        cyc    = 0;
        while (m_count < target && cyc < budget) begin
            @(posedge CLK);
            cyc++;
        end
        if (m_count < target) fail_now("timeout_waiting_for_consumes");
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_imem_req"}, 32'(imem_req), 32'd0);
        check({tag, "_imem_addr"}, imem_addr, RESET_PC);
        check({tag, "_instruction"}, instruction, 32'd0);
        check({tag, "_Ins_Addr"}, Ins_Addr, RESET_PC);
        check({tag, "_ins_valid"}, 32'(ins_valid), 32'd0);
        check({tag, "_fetch_count"}, fetch_count, 32'd0);
    endtask

    initial begin
        int cyc;
        RST = 1'b1;
        model_reset();
        repeat (3) @(negedge CLK);
        check_reset_values("rst");

        // Straight-line flow with a one-cycle memory and an always-ready core.
        ack_pct   = 100;
        ready_pct = 100;
        br_pct    = 0;
        mon_en    = 1'b1;
        drv_en    = 1'b1;
        RST       = 1'b0;
        wait_consumes(4, 100);
        @(negedge CLK);
        check("fetch_count_after_4", fetch_count, 32'd4);

        // Core stalls: the presented instruction must hold.
        ready_pct = 0;
        cyc = 0;
        while (!ins_valid && cyc < 50) begin
            @(negedge CLK);
            cyc++;
        end
        if (!ins_valid) fail_now("timeout_waiting_for_valid");
        repeat (5) @(negedge CLK);
        ready_pct = 100;

        // Randomized branches, jumps, memory latency and core back-pressure.
        ack_pct   = 40;
        ready_pct = 60;
        br_pct    = 30;
        wait_consumes(300, 8000);

        // Reset while a fetch is outstanding; the late ack must be ignored.
        ack_pct = 0;
        cyc = 0;
        @(negedge CLK);
        while (!imem_req && cyc < 50) begin
            @(negedge CLK);
            cyc++;
        end
        if (!imem_req) fail_now("timeout_waiting_for_req");
        drv_en = 1'b0;
        mon_en = 1'b0;
        RST    = 1'b1;
        #1;
        check_reset_values("midfetch_rst");
        ack_pct = 100;
        repeat (3) @(negedge CLK);
        check_reset_values("rst_with_ack");
        model_reset();
        ack_pct   = 60;
        ready_pct = 70;
        br_pct    = 30;
        mon_en    = 1'b1;
        drv_en    = 1'b1;
        RST       = 1'b0;
        wait_consumes(50, 2000);

        drv_en = 1'b0;
        repeat (5) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
